// File: rtl/c_one_hot_therm_pkg.sv
// Shared types and helpers for the pipelined one-hot to thermometer converter.
// Depth and stage count are derived here so top and bench agree on latency.
package c_one_hot_therm_pkg;

  typedef struct packed {
    logic dir;
    logic excl;
  } therm_mode_t;

  // Stage count: ceil(clog2(width) / reg_interval).
  function automatic int therm_num_stages(input int width, input int reg_interval);
    return ($clog2(width) + reg_interval - 1) / reg_interval;
  endfunction

  // Bit-reverse helper: the source index that lands on position idx of a w-bit word.
  function automatic int therm_bit_rev_idx(input int idx, input int w);
    return w - 1 - idx;
  endfunction

endpackage

// File: rtl/c_one_hot_therm_stage.sv
// One pipeline stage of one lane: a run of OR-shift levels feeding a register.
// The last stage also applies the exclusive shift and the exit bit-reversal.
module c_one_hot_therm_stage
  import c_one_hot_therm_pkg::*;
#(
  parameter int width       = 8,
  parameter int first_level = 0,
  parameter int num_levels  = 1,
  parameter bit is_last     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  therm_mode_t      mode,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] lvl [num_levels+1];
  logic [width-1:0] shifted;
  logic [width-1:0] rev;
  logic [width-1:0] nxt;
  logic             excl_en;
  logic             dir_en;

  assign lvl[0] = din;

  // Level l spreads every set bit 2^l positions toward higher indices.
  for (genvar l = 0; l < num_levels; l++) begin : g_lvl
    assign lvl[l+1] = lvl[l] | (lvl[l] << (1 << (first_level + l)));
  end

  assign excl_en = is_last & mode.excl;
  assign dir_en  = is_last & mode.dir;
  assign shifted = excl_en ? (lvl[num_levels] << 1) : lvl[num_levels];

  for (genvar i = 0; i < width; i++) begin : g_rev
    localparam int src = therm_bit_rev_idx(i, width);
    assign rev[i] = shifted[src];
  end

  assign nxt = dir_en ? rev : shifted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (load) begin
      dout <= nxt;
    end
  end

endmodule

// File: rtl/c_one_hot_therm_pipe.sv
// Pipelined multi-channel one-hot to thermometer converter with valid/ready.
// Optional per-channel one-hot checker enabled by defining C_ONE_HOT_THERM_CHECK_EN.
module c_one_hot_therm_pipe
  import c_one_hot_therm_pkg::*;
#(
  parameter int width        = 8,
  parameter int num_channels = 1,
  parameter int reg_interval = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_dir,
  input  logic                          in_excl,
  input  logic [0:num_channels*width-1] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:num_channels*width-1] out_data,
  output logic [num_channels-1:0]       out_err
);

  localparam int depth      = $clog2(width);
  localparam int num_stages = therm_num_stages(width, reg_interval);

  logic [num_stages-1:0] v;
  logic [num_stages-1:0] rdy;
  logic [num_stages-1:0] up_valid;
  logic [num_stages-1:0] load;
  therm_mode_t           up_mode [num_stages];

  // Handshake: a transfer happens on any edge where valid and ready are both high;
  // a stage can take new data when it is empty or its successor is taking its data.
  always_comb begin : p_ready
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = num_stages - 1; k >= 0; k--) begin
      r      = ~v[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0] & ~clear;

  always_comb begin
    up_valid    = '0;
    up_valid[0] = in_valid & in_ready;
    for (int k = 1; k < num_stages; k++) begin
      up_valid[k] = v[k-1];
    end
    load = rdy & up_valid & {num_stages{~clear}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
    end else if (clear) begin
      v <= '0;
    end else begin
      v <= (v & ~rdy) | (up_valid & rdy);
    end
  end

  assign out_valid  = v[num_stages-1];
  assign up_mode[0] = therm_mode_t'{dir: in_dir, excl: in_excl};

  // Mode rides with its data; only the last stage consumes it.
  if (num_stages > 1) begin : g_mode
    therm_mode_t mode_q [num_stages-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < num_stages - 1; k++) mode_q[k] <= '0;
      end else begin
        for (int k = 0; k < num_stages - 1; k++) begin
          if (load[k]) mode_q[k] <= up_mode[k];
        end
      end
    end

    for (genvar k = 1; k < num_stages; k++) begin : g_up
      assign up_mode[k] = mode_q[k-1];
    end
  end

  for (genvar c = 0; c < num_channels; c++) begin : g_ch
    logic [width-1:0] x;
    logic [width-1:0] x_rev;
    logic [width-1:0] sd [num_stages+1];

    for (genvar i = 0; i < width; i++) begin : g_bit
      localparam int src = therm_bit_rev_idx(i, width);
      assign x[i]                  = in_data[c*width + i];
      assign x_rev[i]              = in_data[c*width + src];
      assign out_data[c*width + i] = sd[num_stages][i];
    end

    assign sd[0] = in_dir ? x_rev : x;

    for (genvar k = 0; k < num_stages; k++) begin : g_stage
      localparam int lvl_first = k * reg_interval;
      localparam int lvl_end   = ((k + 1) * reg_interval < depth) ? (k + 1) * reg_interval : depth;

      c_one_hot_therm_stage #(
        .width      (width),
        .first_level(lvl_first),
        .num_levels (lvl_end - lvl_first),
        .is_last    (k == num_stages - 1)
      ) u_stage (
        .clk  (clk),
        .reset(reset),
        .load (load[k]),
        .mode (up_mode[k]),
        .din  (sd[k]),
        .dout (sd[k+1])
      );
    end

`ifdef C_ONE_HOT_THERM_CHECK_EN
    logic [num_stages-1:0] err_q;
    logic [num_stages-1:0] err_up;

    always_comb begin
      err_up    = '0;
      err_up[0] = ($countones(x) != 1);
      for (int k = 1; k < num_stages; k++) begin
        err_up[k] = err_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        err_q <= '0;
      end else begin
        err_q <= (err_q & ~load) | (err_up & load);
      end
    end

    assign out_err[c] = err_q[num_stages-1];
`else
    assign out_err[c] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_c_one_hot_therm_pipe.sv
// Bench for c_one_hot_therm_pipe: width=8, two channels, one level per stage (3 stages).
// Expected err flags follow C_ONE_HOT_THERM_CHECK_EN.
module tb_c_one_hot_therm_pipe;

  localparam int W  = 8;
  localparam int NC = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic            in_dir;
  logic            in_excl;
  logic [0:NC*W-1] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [0:NC*W-1] out_data;
  logic [NC-1:0]   out_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dir;
    logic       excl;
    logic [7:0] ch0;
    logic [7:0] ch1;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic [1:0] err;
  } vec_t;

  vec_t        vecs [8];
  logic [17:0] exp_q [$];

  c_one_hot_therm_pipe #(
    .width       (W),
    .num_channels(NC),
    .reg_interval(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dir   (in_dir),
    .in_excl  (in_excl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference straight from the prefix-OR definition; string bit 0 is vector bit 7.
  function automatic logic [7:0] model(input logic [7:0] x, input logic dir, input logic excl);
    logic [7:0] y;
    logic       hit;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (!dir) hit = excl ? (j < i) : (j <= i);
        else      hit = excl ? (j > i) : (j >= i);
        if (hit && x[7-j]) y[7-i] = 1'b1;
      end
    end
    return y;
  endfunction

  function automatic logic err_of(input logic [7:0] x);
`ifdef C_ONE_HOT_THERM_CHECK_EN
    return ($countones(x) != 1);
`else
    return (x != x);
`endif
  endfunction

  task automatic run_vec(input string tag, input vec_t t);
    logic [1:0] e;
    e = t.err;
`ifndef C_ONE_HOT_THERM_CHECK_EN
    e = 2'b00;
`endif
    in_valid = 1'b1;
    in_dir   = t.dir;
    in_excl  = t.excl;
    in_data  = {t.ch0, t.ch1};
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk({tag, "_early_valid"}, out_valid, 0);
    next_cycle();
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ch0"}, out_data[0:7], t.exp0);
    chk({tag, "_ch1"}, out_data[8:15], t.exp1);
    chk({tag, "_err"}, out_err, e);
    next_cycle();
  endtask

  initial begin
    int         sent;
    int         got;
    int         cnt;
    logic       stall_seen;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [17:0] e;

    vecs[0] = '{dir: 1'b0, excl: 1'b0, ch0: 8'b00100000, ch1: 8'b00000001, exp0: 8'b00111111, exp1: 8'b00000001, err: 2'b00};
    vecs[1] = '{dir: 1'b0, excl: 1'b1, ch0: 8'b00100000, ch1: 8'b00000001, exp0: 8'b00011111, exp1: 8'b00000000, err: 2'b00};
    vecs[2] = '{dir: 1'b1, excl: 1'b0, ch0: 8'b00100000, ch1: 8'b10000000, exp0: 8'b11100000, exp1: 8'b10000000, err: 2'b00};
    vecs[3] = '{dir: 1'b1, excl: 1'b1, ch0: 8'b00100000, ch1: 8'b10000000, exp0: 8'b11000000, exp1: 8'b00000000, err: 2'b00};
    vecs[4] = '{dir: 1'b0, excl: 1'b0, ch0: 8'b00000000, ch1: 8'b01000100, exp0: 8'b00000000, exp1: 8'b01111111, err: 2'b11};
    vecs[5] = '{dir: 1'b1, excl: 1'b0, ch0: 8'b01000100, ch1: 8'b00010000, exp0: 8'b11111100, exp1: 8'b11110000, err: 2'b01};
    vecs[6] = '{dir: 1'b0, excl: 1'b1, ch0: 8'b10000000, ch1: 8'b00000010, exp0: 8'b01111111, exp1: 8'b00000001, err: 2'b00};
    vecs[7] = '{dir: 1'b1, excl: 1'b1, ch0: 8'b00000001, ch1: 8'b01000000, exp0: 8'b11111110, exp1: 8'b10000000, err: 2'b00};

    // Clock/reset
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_dir = 1'b0; in_excl = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    next_cycle();

    // Mode sweep and illegal codes
    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure with scoreboard
    sent = 0; got = 0; cnt = 0; stall_seen = 1'b0;
    for (int t = 0; t < 40 && got < 10; t++) begin
      out_ready = !(t >= 4 && t <= 8);
      if (sent < 10) begin
        in_valid = 1'b1;
        in_dir   = sent[0];
        in_excl  = sent[1];
        a0       = 8'h80 >> (sent % 8);
        a1       = 8'h01 << (sent % 8);
        in_data  = {a0, a1};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_in_ready", in_ready, (cnt < 3) || out_ready);
      if (!out_ready && !in_ready) stall_seen = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("bp_data", out_data, e[15:0]);
          chk("bp_err", out_err, e[17:16]);
        end
        got++;
        cnt--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({err_of(a1), err_of(a0), model(a0, in_dir, in_excl), model(a1, in_dir, in_excl)});
        sent++;
        cnt++;
      end
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_received", got, 10);
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_stall_seen", stall_seen, 1);

    // Clear with two transactions in flight and a competing input
    in_valid = 1'b1; in_dir = 1'b0; in_excl = 1'b0;
    in_data = {8'b00000001, 8'b00000001};
    next_cycle();
    in_data = {8'b00000010, 8'b00000010};
    next_cycle();
    clear = 1'b1;
    in_data = {8'b10000000, 8'b10000000};
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    next_cycle();
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("clr_out_valid%0d", i), out_valid, 0);
      next_cycle();
    end
    run_vec("post_clr", vecs[2]);

    // Reset mid-stream with a full pipeline
    out_ready = 1'b0; in_valid = 1'b1; in_dir = 1'b0; in_excl = 1'b0;
    in_data = {8'b00000001, 8'b11000000};
    repeat (3) next_cycle();
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_ch1", out_data[8:15], 8'hFF);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_err", out_err, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    run_vec("post_rst", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
